// File: rtl/mor1kx_branch_predictor_ctrl_pkg.sv
// Shared definitions for the branch predictor sequencing controller:
// state encodings, state width and the flag-to-direction helper.
package mor1kx_branch_predictor_ctrl_pkg;

   localparam int BP_CTRL_STATE_W = 2;

   typedef enum logic [BP_CTRL_STATE_W-1:0] {
      BP_CTRL_IDLE     = 2'd0,
      BP_CTRL_PENDING  = 2'd1,
      BP_CTRL_REDIRECT = 2'd2
   } bp_ctrl_state_t;

   // l.bf is taken when SR[F] is set, l.bnf when it is clear.
   function automatic logic bp_actual_taken(input logic is_bf, input logic flag);
      return is_bf ? flag : ~flag;
   endfunction

endpackage

// File: rtl/mor1kx_bp_stat_counter.sv
// Saturating statistics counter with synchronous clear; clear beats increment.
// Only built when MOR1KX_BP_STATS_EN is defined.
`ifdef MOR1KX_BP_STATS_EN
module mor1kx_bp_stat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Counter register: stops at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {WIDTH{1'b0}};
      end else if (clear) begin
         count <= {WIDTH{1'b0}};
      end else if (inc && (count != COUNT_MAX)) begin
         count <= count + COUNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule
`endif

// File: rtl/mor1kx_branch_predictor_ctrl.sv
// Tracks one in-flight conditional branch from decode to execute and issues a
// fetch redirect on mispredict. Statistics counters exist when MOR1KX_BP_STATS_EN is defined.
module mor1kx_branch_predictor_ctrl
   import mor1kx_branch_predictor_ctrl_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int STATS_WIDTH          = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            padv_decode_i,
   input  logic                            decode_op_bf_i,
   input  logic                            decode_op_bnf_i,
   input  logic                            predicted_taken_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] decode_branch_target_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] decode_fallthrough_pc_i,
   input  logic                            flag_valid_i,
   input  logic                            execute_flag_i,
   input  logic                            pipeline_flush_i,
   input  logic                            fetch_redirect_ack_i,
   input  logic                            stats_clear_i,
   output logic                            stall_decode_o,
   output logic                            branch_pending_o,
   output logic                            mispredict_o,
   output logic                            redirect_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
   output logic [STATS_WIDTH-1:0]          branch_count_o,
   output logic [STATS_WIDTH-1:0]          mispredict_count_o
);

   bp_ctrl_state_t                  state;
   logic                            cap_bf;
   logic                            cap_pred;
   logic [OPTION_OPERAND_WIDTH-1:0] cap_target;
   logic [OPTION_OPERAND_WIDTH-1:0] cap_fallthrough;

   logic dec_br;
   logic actual_taken;
   logic match;
   logic resolve;
   logic capture;
   logic branch_inc;
   logic mispredict_inc;

   // Decode/resolve qualifiers; a flush blocks both capture and resolution.
   always_comb begin
      dec_br         = decode_op_bf_i | decode_op_bnf_i;
      actual_taken   = bp_actual_taken(cap_bf, execute_flag_i);
      match          = (actual_taken == cap_pred);
      resolve        = (state == BP_CTRL_PENDING) & flag_valid_i & ~pipeline_flush_i;
      capture        = padv_decode_i & dec_br & ~pipeline_flush_i &
                       ((state == BP_CTRL_IDLE) | (resolve & match));
      branch_inc     = resolve;
      mispredict_inc = resolve & ~match;
      stall_decode_o = dec_br & ((state == BP_CTRL_REDIRECT) |
                       ((state == BP_CTRL_PENDING) & ~(flag_valid_i & match)));
   end

   assign branch_pending_o = (state == BP_CTRL_PENDING);

   // Captured branch: only overwritten by a right-path decode branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_bf          <= 1'b0;
         cap_pred        <= 1'b0;
         cap_target      <= {OPTION_OPERAND_WIDTH{1'b0}};
         cap_fallthrough <= {OPTION_OPERAND_WIDTH{1'b0}};
      end else if (capture) begin
         cap_bf          <= decode_op_bf_i;
         cap_pred        <= predicted_taken_i;
         cap_target      <= decode_branch_target_i;
         cap_fallthrough <= decode_fallthrough_pc_i;
      end else begin
         cap_bf          <= cap_bf;
         cap_pred        <= cap_pred;
         cap_target      <= cap_target;
         cap_fallthrough <= cap_fallthrough;
      end
   end

   // Controller FSM with registered mispredict/redirect outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BP_CTRL_IDLE;
         mispredict_o  <= 1'b0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= {OPTION_OPERAND_WIDTH{1'b0}};
      end else begin
         mispredict_o <= 1'b0;
         if (pipeline_flush_i) begin
            state      <= BP_CTRL_IDLE;
            redirect_o <= 1'b0;
         end else begin
            case (state)
               BP_CTRL_IDLE: begin
                  state <= capture ? BP_CTRL_PENDING : BP_CTRL_IDLE;
               end
               BP_CTRL_PENDING: begin
                  if (flag_valid_i && match) begin
                     state <= capture ? BP_CTRL_PENDING : BP_CTRL_IDLE;
                  end else if (flag_valid_i) begin
                     state         <= BP_CTRL_REDIRECT;
                     mispredict_o  <= 1'b1;
                     redirect_o    <= 1'b1;
                     redirect_pc_o <= actual_taken ? cap_target : cap_fallthrough;
                  end else begin
                     state <= BP_CTRL_PENDING;
                  end
               end
               BP_CTRL_REDIRECT: begin
                  if (fetch_redirect_ack_i) begin
                     state      <= BP_CTRL_IDLE;
                     redirect_o <= 1'b0;
                  end else begin
                     state <= BP_CTRL_REDIRECT;
                  end
               end
               default: begin
                  state      <= BP_CTRL_IDLE;
                  redirect_o <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef MOR1KX_BP_STATS_EN
   mor1kx_bp_stat_counter #(
      .WIDTH (STATS_WIDTH)
   ) u_branch_count (
      .clk   (clk),
      .rst   (rst),
      .clear (stats_clear_i),
      .inc   (branch_inc),
      .count (branch_count_o)
   );

   mor1kx_bp_stat_counter #(
      .WIDTH (STATS_WIDTH)
   ) u_mispredict_count (
      .clk   (clk),
      .rst   (rst),
      .clear (stats_clear_i),
      .inc   (mispredict_inc),
      .count (mispredict_count_o)
   );
`else
   logic unused_stats;

   assign branch_count_o     = {STATS_WIDTH{1'b0}};
   assign mispredict_count_o = {STATS_WIDTH{1'b0}};
   assign unused_stats       = stats_clear_i ^ branch_inc ^ mispredict_inc;
`endif

endmodule

// File: tb/tb_mor1kx_branch_predictor_ctrl.sv
// Directed bench for mor1kx_branch_predictor_ctrl with a transaction-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_mor1kx_branch_predictor_ctrl;

   localparam int W    = 32;
   localparam int SW   = 4;
   localparam int SMAX = 15;
`ifdef MOR1KX_BP_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          padv = 1'b0, op_bf = 1'b0, op_bnf = 1'b0, pred = 1'b0;
   logic [W-1:0]  target = '0, fallthrough = '0;
   logic          flag_valid = 1'b0, flag = 1'b0, flush = 1'b0, ack = 1'b0, clr = 1'b0;
   logic          stall, pending, mispredict, redirect;
   logic [W-1:0]  redirect_pc;
   logic [SW-1:0] branch_count, mispredict_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mor1kx_branch_predictor_ctrl #(
      .OPTION_OPERAND_WIDTH (W),
      .STATS_WIDTH          (SW)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .padv_decode_i           (padv),
      .decode_op_bf_i          (op_bf),
      .decode_op_bnf_i         (op_bnf),
      .predicted_taken_i       (pred),
      .decode_branch_target_i  (target),
      .decode_fallthrough_pc_i (fallthrough),
      .flag_valid_i            (flag_valid),
      .execute_flag_i          (flag),
      .pipeline_flush_i        (flush),
      .fetch_redirect_ack_i    (ack),
      .stats_clear_i           (clr),
      .stall_decode_o          (stall),
      .branch_pending_o        (pending),
      .mispredict_o            (mispredict),
      .redirect_o              (redirect),
      .redirect_pc_o           (redirect_pc),
      .branch_count_o          (branch_count),
      .mispredict_count_o      (mispredict_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one in-flight branch, a redirect flag, and integer counters.
   bit          m_valid = 1'b0;
   bit          m_pending, m_redir, m_mis, m_bf, m_pred;
   logic [31:0] m_tgt, m_fall, m_rpc;
   int          m_bc, m_mc;

   function automatic int sat(input int v);
      return (v > SMAX) ? SMAX : v;
   endfunction

   function automatic bit model_taken();
      return m_bf ? flag : !flag;
   endfunction

   always @(posedge clk) begin : model
      bit dec, act;
      dec = op_bf | op_bnf;
      act = model_taken();
      if (rst) begin
         m_valid = 1'b1; m_pending = 1'b0; m_redir = 1'b0; m_mis = 1'b0;
         m_bf = 1'b0; m_pred = 1'b0; m_tgt = '0; m_fall = '0; m_rpc = '0;
         m_bc = 0; m_mc = 0;
      end else begin
         m_mis = 1'b0;
         if (flush) begin
            m_pending = 1'b0;
            m_redir   = 1'b0;
         end else if (m_redir) begin
            if (ack) m_redir = 1'b0;
         end else if (m_pending) begin
            if (flag_valid) begin
               if (STATS_ON) m_bc = sat(m_bc + 1);
               if (act == m_pred) begin
                  m_pending = padv && dec;
                  if (padv && dec) begin
                     m_bf = op_bf; m_pred = pred; m_tgt = target; m_fall = fallthrough;
                  end
               end else begin
                  if (STATS_ON) m_mc = sat(m_mc + 1);
                  m_mis = 1'b1; m_redir = 1'b1; m_pending = 1'b0;
                  m_rpc = act ? m_tgt : m_fall;
               end
            end
         end else if (padv && dec) begin
            m_bf = op_bf; m_pred = pred; m_tgt = target; m_fall = fallthrough;
            m_pending = 1'b1;
         end
         if (STATS_ON && clr) begin
            m_bc = 0;
            m_mc = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (m_valid) begin
         check("stall_decode", 32'(stall), 32'((op_bf | op_bnf) &
               (m_redir | (m_pending & !(flag_valid & (model_taken() == m_pred))))));
         check("branch_pending", 32'(pending), 32'(m_pending));
         check("mispredict", 32'(mispredict), 32'(m_mis));
         check("redirect", 32'(redirect), 32'(m_redir));
         check("redirect_pc", redirect_pc, m_rpc);
         check("branch_count", 32'(branch_count), 32'(m_bc));
         check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
      end
   end

   task automatic drive(input logic p, input logic bf, input logic bnf, input logic pr,
                        input logic [31:0] t, input logic [31:0] f, input logic fv,
                        input logic fl, input logic fu, input logic ak, input logic sc);
      padv = p; op_bf = bf; op_bnf = bnf; pred = pr; target = t; fallthrough = f;
      flag_valid = fv; flag = fl; flush = fu; ack = ak; clr = sc;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sx(input int v);
      return STATS_ON ? 32'(v) : 32'h0;
   endfunction

   initial begin
      idle_in();
      rst = 1'b1;
      tick(); tick();
      check("reset redirect", 32'(redirect), 32'h0);
      check("reset redirect_pc", redirect_pc, 32'h0);
      check("reset pending", 32'(pending), 32'h0);
      check("reset branch_count", 32'(branch_count), 32'h0);
      rst = 1'b0;

      // Correct prediction: l.bf predicted taken, flag set.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("capture pending", 32'(pending), 32'h1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("correct no mispredict", 32'(mispredict), 32'h0);
      check("correct idle", 32'(pending), 32'h0);
      check("correct branch_count", 32'(branch_count), sx(1));
      idle_in(); tick();

      // Mispredict: l.bnf predicted taken, flag set -> fallthrough 0x208.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("mis pulse", 32'(mispredict), 32'h1);
      check("mis redirect", 32'(redirect), 32'h1);
      check("mis redirect_pc", redirect_pc, 32'h208);
      idle_in(); tick();
      check("mis pulse one cycle", 32'(mispredict), 32'h0);
      check("mis redirect held", 32'(redirect), 32'h1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      check("ack drops redirect", 32'(redirect), 32'h0);
      check("mispredict_count", 32'(mispredict_count), sx(1));
      idle_in(); tick();

      // Back-to-back, first correct: second branch captured without stall.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h308, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      check("b2b no stall", 32'(stall), 32'h0);
      tick();
      check("b2b captured", 32'(pending), 32'h1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("b2b resolved", 32'(pending), 32'h0);
      check("b2b count", 32'(branch_count), sx(4));

      // Back-to-back, first mispredicts: second branch stalled, not captured.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h508, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h608, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      check("b2b mis stall", 32'(stall), 32'h1);
      tick();
      check("b2b mis redirect_pc", redirect_pc, 32'h500);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h608, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      check("redirect stall", 32'(stall), 32'h1);
      tick();
      check("min redirect", 32'(redirect), 32'h0);
      check("wrong path dropped", 32'(pending), 32'h0);

      // Stall while pending without resolution.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 32'h708, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h808, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      check("pending stall", 32'(stall), 32'h1);
      tick(); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h800, 32'h808, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      check("stall released", 32'(stall), 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("stall seq count", 32'(branch_count), sx(7));

      // Flush in PENDING.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 32'h908, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      check("flush pending", 32'(pending), 32'h0);
      check("flush count", 32'(branch_count), sx(7));

      // Flush in REDIRECT with flag data present.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'ha00, 32'ha08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("redirect_pc a08", redirect_pc, 32'ha08);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      check("flush redirect", 32'(redirect), 32'h0);
      check("flush mis count", 32'(mispredict_count), sx(3));

      // Flush together with ack.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hb00, 32'hb08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
      check("flush+ack idle", 32'(redirect), 32'h0);

      // Reset mid-redirect.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hc00, 32'hc08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("pre-reset redirect", 32'(redirect), 32'h1);
      idle_in(); rst = 1'b1; tick();
      check("reset drops redirect", 32'(redirect), 32'h0);
      check("reset clears pc", redirect_pc, 32'h0);
      rst = 1'b0;

      // Saturation: 17 correctly predicted branches.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hd00, 32'hd08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      end
      check("saturated count", 32'(branch_count), sx(15));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'he00, 32'he08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
      check("clear beats inc", 32'(branch_count), 32'h0);
      check("clear mis count", 32'(mispredict_count), 32'h0);
      idle_in(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mor1kx_branch_predictor_ctrl.md
# mor1kx_branch_predictor_ctrl

Sequencing controller for the static branch predictor. It captures each conditional branch (l.bf/l.bnf) and its prediction at decode, holds it until execute resolves the flag, and on a mispredict drives a fetch redirect with the correct PC. One branch may be in flight; a second conditional branch is stalled in decode until the first resolves. Optional saturating statistics counters are included.

## Interface
- OPTION_OPERAND_WIDTH, 32, PC/target width
- STATS_WIDTH, 32, width of statistics counters
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- padv_decode_i  in  1  decode stage advances this cycle
- decode_op_bf_i  in  1  decode holds l.bf
- decode_op_bnf_i  in  1  decode holds l.bnf
- predicted_taken_i  in  1  predictor output for the decode branch (1 = taken)
- decode_branch_target_i  in  OPTION_OPERAND_WIDTH  taken target
- decode_fallthrough_pc_i  in  OPTION_OPERAND_WIDTH  not-taken PC (after delay slot)
- flag_valid_i  in  1  execute has resolved the flag for the pending branch
- execute_flag_i  in  1  resolved SR[F]
- pipeline_flush_i  in  1  exception/rfe flush
- fetch_redirect_ack_i  in  1  fetch accepted redirect
- stats_clear_i  in  1  clear statistics counters
- stall_decode_o  out  1  hold decode (combinational)
- branch_pending_o  out  1  branch awaiting resolution
- mispredict_o  out  1  one-cycle mispredict pulse
- redirect_o  out  1  redirect request, held until ack
- redirect_pc_o  out  OPTION_OPERAND_WIDTH  correct PC
- branch_count_o  out  STATS_WIDTH  resolved branches
- mispredict_count_o  out  STATS_WIDTH  mispredicts

## Operation
- dec_br = decode_op_bf_i | decode_op_bnf_i.
- States: IDLE, PENDING, REDIRECT.
- IDLE: padv_decode_i & dec_br -> capture op type, predicted_taken_i, target, fallthrough; go PENDING. flag_valid_i ignored.
- PENDING: on flag_valid_i, actual_taken = bf ? execute_flag_i : !execute_flag_i.
  - Match: go IDLE, or stay PENDING with a fresh capture if padv_decode_i & dec_br in the same cycle.
  - Mismatch: redirect_pc_o <= actual_taken ? target : fallthrough; go REDIRECT. Any same-cycle decode branch is not captured (wrong path).
- REDIRECT: redirect_o = 1; go IDLE on fetch_redirect_ack_i. Decode branches not captured.
- stall_decode_o = dec_br & (state==REDIRECT | (state==PENDING & !(flag_valid_i & match))).
- pipeline_flush_i: highest priority; any state -> IDLE next cycle; no redirect; no counter update for an unresolved branch; mispredict_o suppressed.
- branch_pending_o = (state==PENDING).

## Timing
- Reset: state IDLE; all outputs 0, including redirect_pc_o and counters.
- mispredict_o, redirect_o, redirect_pc_o are registered and assert the cycle after the mismatching flag_valid_i. mispredict_o lasts exactly one cycle.
- redirect_o and redirect_pc_o are stable until the ack cycle. The ack in the first REDIRECT cycle is honoured, giving a minimum 1-cycle redirect.
- Capture is registered. flag_valid_i can resolve at earliest the cycle after capture.
- Flush and ack in the same cycle: go IDLE.
- Reset mid-redirect: redirect_o drops the next cycle.

## Configuration
- MOR1KX_BP_STATS_EN defined:
  - branch_count_o increments on each resolved branch.
  - mispredict_count_o increments on each mismatch.
  - Both saturate at all-ones.
  - stats_clear_i zeroes both and wins over a same-cycle increment.
- Undefined: both outputs tied 0, stats_clear_i ignored, no counter flops; ports remain.

## Structure
- Shared package/defines: state encodings (BP_CTRL_IDLE/PENDING/REDIRECT) and the state width.
- Sub-module mor1kx_bp_stat_counter: saturating counter with clear and increment, instantiated twice, only under MOR1KX_BP_STATS_EN.

## Test plan
- Correct prediction: l.bf with predicted_taken=1, flag_valid with flag=1 -> no mispredict_o; back to IDLE; branch_count=1, mispredict_count=0.
- Mispredict: l.bnf with predicted_taken=1, target=0x100, fallthrough=0x208; resolve flag=1 -> next cycle mispredict_o pulse, redirect_o=1, redirect_pc_o=0x208; held 3 cycles until ack; then IDLE; mispredict_count=1.
- Back-to-back: second branch decoded the cycle the first resolves correctly -> captured, no stall. If the first had mispredicted -> stall_decode_o=1 and no capture.
- Stall: second branch in decode while PENDING without flag_valid -> stall_decode_o=1 until resolution.
- Flush: pipeline_flush_i in PENDING, or in REDIRECT with flag data present -> IDLE next cycle, redirect_o=0, counters unchanged.
- Saturation (STATS_WIDTH=4): 17 resolved branches -> branch_count_o=15; stats_clear_i together with an increment -> 0. Without macro -> counters always 0.
